sample_player_mc: RTL



---
 rtl/sample_player_mc.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sample_player_mc.sv
// sample_player_mc: multi-voice 8-bit sample player sharing one ROM port, with a saturating signed mixer
// Ports: clk_bram/reset (async, active-high); ce base rate enable; bram_wr/bram_offsets_cs/bram_addr/bram_data
//   offset-table download; trig_en/trig_chan/trig_code voice triggers (0xFF stops a voice); rom_req/rom_addr/
//   rom_ack/rom_data shared sample fetch port; busy per-voice playing; underrun sticky starvation flag;
//   active offset table non-empty; mix_out signed saturated mix.
// Define SAMPLE_PLAYER_VOLUME_EN to add trig_vol, a 4-bit per-voice volume latched on trigger.
module sample_player_mc #(
    parameter int CHANNELS     = 2,
    parameter int OFFSET_DEPTH = 64,
    parameter int ADDR_W       = 18,
    parameter int RATE_DIV     = 1024,
    localparam int CW          = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_bram,
    input  logic                reset,
    input  logic                ce,
    input  logic                bram_wr,
    input  logic                bram_offsets_cs,
    input  logic [19:0]         bram_addr,
    input  logic [7:0]          bram_data,
    input  logic                trig_en,
    input  logic [CW-1:0]       trig_chan,
    input  logic [7:0]          trig_code,
`ifdef SAMPLE_PLAYER_VOLUME_EN
    input  logic [3:0]          trig_vol,
`endif
    output logic                rom_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic                rom_ack,
    input  logic [7:0]          rom_data,
    output logic [CHANNELS-1:0] busy,
    output logic                underrun,
    output logic                active,
    output logic [15:0]         mix_out
);
    localparam int IW = OFFSET_DEPTH > 1 ? $clog2(OFFSET_DEPTH) : 1;
    localparam int TW = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

    logic [ADDR_W-1:0]   tbl_q [OFFSET_DEPTH];
    logic [7:0]          b1_q, b2_q;
    logic [IW:0]         cnt_q;
    logic [TW-1:0]       div_q;
    state_t              st_q [CHANNELS];
    logic [ADDR_W-1:0]   addr_q [CHANNELS];
    logic [7:0]          cur_q [CHANNELS];
    logic [7:0]          nxt_q [CHANNELS];
    logic                req_q, drop_q, und_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic [CW-1:0]       gch_q, last_q, sel;
    logic [15:0]         mix_q, mix_d;
    logic [CHANNELS-1:0] hit, elig;
    logic                gnt, wr_ok, stop, start, tick, ack_ok;
    logic signed [19:0]  sum;
    logic [23:0]         wval;
    logic [IW-1:0]       widx;
`ifdef SAMPLE_PLAYER_VOLUME_EN
    logic [3:0]          vol_q [CHANNELS];
    logic signed [12:0]  prod;
`endif

    assign wr_ok  = bram_wr && bram_offsets_cs && {14'd0, bram_addr[19:2]} < 32'(OFFSET_DEPTH);
    assign widx   = bram_addr[IW+1:2];
    assign wval   = {b1_q, b2_q, bram_data};
    assign stop   = trig_en && trig_code == 8'hFF;
    assign start  = trig_en && trig_code != 8'hFF && 32'(trig_code) < 32'(cnt_q);
    assign tick   = ce && div_q == TW'(RATE_DIV - 1);
    // A flagged in-flight fetch belongs to a voice that was retriggered or stopped; its data is dropped.
    assign ack_ok = req_q && rom_ack && !drop_q && !hit[gch_q];

    assign rom_req  = req_q;
    assign rom_addr = raddr_q;
    assign underrun = und_q;
    assign active   = cnt_q != '0;
    assign mix_out  = mix_q;

    always_comb begin
        hit  = '0;
        elig = '0;
        busy = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hit[c]  = (start || stop) && 32'(trig_chan) == c;
            elig[c] = st_q[c] == FETCH && !hit[c];
            busy[c] = st_q[c] != IDLE;
        end
    end

    // Round-robin: scan downward so the voice nearest after the last grant is assigned last and wins.
    always_comb begin
        gnt = 1'b0;
        sel = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            int j;
            j = (int'(last_q) + k) % CHANNELS;
            if (elig[j]) begin
                gnt = 1'b1;
                sel = CW'(j);
            end
        end
    end

    always_comb begin
        sum = '0;
`ifdef SAMPLE_PLAYER_VOLUME_EN
        prod = '0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
`ifdef SAMPLE_PLAYER_VOLUME_EN
            prod = $signed({~cur_q[c][7], cur_q[c][6:0]}) * $signed({1'b0, vol_q[c]});
            sum  = sum + {{3{prod[12]}}, prod, 4'h0};
`else
            sum  = sum + {{5{~cur_q[c][7]}}, cur_q[c][6:0], 8'h00};
`endif
        end
        mix_d = sum > 20'sd32767 ? 16'h7FFF : sum < -20'sd32768 ? 16'h8000 : sum[15:0];
    end

    // Table contents survive reset; only the entry count is cleared.
    always_ff @(posedge clk_bram) begin
        if (wr_ok && bram_addr[1:0] == 2'd3)
            tbl_q[widx] <= wval[ADDR_W-1:0];
    end

    always_ff @(posedge clk_bram or posedge reset) begin
        if (reset) begin
            b1_q    <= '0;
            b2_q    <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            und_q   <= 1'b0;
            raddr_q <= '0;
            gch_q   <= '0;
            last_q  <= '0;
            mix_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]   <= IDLE;
                addr_q[c] <= '0;
                cur_q[c]  <= 8'h80;
                nxt_q[c]  <= '0;
`ifdef SAMPLE_PLAYER_VOLUME_EN
                vol_q[c]  <= '0;
`endif
            end
        end else begin
            if (wr_ok && bram_addr[1:0] == 2'd1) b1_q <= bram_data;
            if (wr_ok && bram_addr[1:0] == 2'd2) b2_q <= bram_data;
            if (wr_ok && bram_addr[1:0] == 2'd3 && {1'b0, widx} >= cnt_q) cnt_q <= {1'b0, widx} + 1'b1;
            if (ce) div_q <= tick ? '0 : div_q + 1'b1;
            if (req_q) begin
                if (hit[gch_q]) drop_q <= 1'b1;
                if (rom_ack) req_q <= 1'b0;
            end else begin
                drop_q <= 1'b0;
                if (gnt) begin
                    req_q   <= 1'b1;
                    raddr_q <= addr_q[sel];
                    gch_q   <= sel;
                    last_q  <= sel;
                end
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (tick && st_q[c] == FETCH && !hit[c]) und_q <= 1'b1;
                if (hit[c]) begin
                    cur_q[c] <= 8'h80;
                    st_q[c]  <= stop ? IDLE : FETCH;
                    if (!stop) addr_q[c] <= tbl_q[trig_code[IW-1:0]];
`ifdef SAMPLE_PLAYER_VOLUME_EN
                    if (!stop) vol_q[c] <= trig_vol;
`endif
                end else if (st_q[c] == FETCH) begin
                    if (ack_ok && gch_q == CW'(c)) begin
                        nxt_q[c]  <= rom_data;
                        addr_q[c] <= addr_q[c] + 1'b1;
                        st_q[c]   <= READY;
                    end
                end else if (st_q[c] == READY && tick) begin
                    cur_q[c] <= nxt_q[c] == 8'h00 ? 8'h80 : nxt_q[c];
                    st_q[c]  <= nxt_q[c] == 8'h00 ? IDLE : FETCH;
                end
            end
            mix_q <= mix_d;
        end
    end
endmodule
